// File: rtl/jtkunio_objbuf_pkg.sv
// rtl/jtkunio_objbuf_pkg.sv - shared constants and types for the object line buffer
package jtkunio_objbuf_pkg;

    localparam int OBJ_AW = 9;
    localparam int OBJ_DW = 5;

    // Colour nibble value that means "no object pixel here"
    localparam logic [3:0] TRANSP = 4'h0;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } clr_state_t;

    function automatic logic is_opaque(input logic [3:0] colour);
        return colour != TRANSP;
    endfunction

endpackage

// File: rtl/jtframe_dual_ram.sv
// rtl/jtframe_dual_ram.sv - one line-buffer bank: write-only port A, async-read/write port B
module jtframe_dual_ram #(
    parameter int DW = 5,
    parameter int AW = 9
)(
    input  logic          clk_i,
    // port A: draw pixels or clear sweep
    input  logic          a_we_i,
    input  logic [AW-1:0] a_addr_i,
    input  logic [DW-1:0] a_din_i,
    // port B: readout and erase-behind-read
    input  logic          b_we_i,
    input  logic [AW-1:0] b_waddr_i,
    input  logic [DW-1:0] b_din_i,
    input  logic [AW-1:0] b_raddr_i,
    output logic [DW-1:0] b_dout_o
);

    logic [DW-1:0] mem [0:(2**AW)-1];

    // Port A is applied last so a draw wins over an erase to the same cell
    always_ff @(posedge clk_i) begin
        if (b_we_i) mem[b_waddr_i] <= b_din_i;
        if (a_we_i) mem[a_addr_i]  <= a_din_i;
    end

    // Read is combinational so the data register sees the address one pixel later
    assign b_dout_o = mem[b_raddr_i];

endmodule

// File: rtl/jtkunio_objbuf.sv
// rtl/jtkunio_objbuf.sv - ping-pong object line buffer between drawer and colour mixer
module jtkunio_objbuf
    import jtkunio_objbuf_pkg::*;
#(
    parameter int AW = OBJ_AW,
    parameter int DW = OBJ_DW
)(
    input  logic          clk,
    input  logic          rst,
    input  logic          pxl_cen,
    input  logic          hs,
    input  logic [8:0]    hdump,
    input  logic          flip,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          wr_en,
    output logic          busy,
    output logic [DW-1:0] pxl
);

    clr_state_t    state_q;
    logic [AW-1:0] clr_cnt_q;
    logic          busy_q;

    logic          bank_q;
    logic          hs_l_q;

    logic [8:0]    scr_addr;
    logic [AW-1:0] rd_addr_d;
    logic [AW-1:0] rd_addr_q;
    logic [DW-1:0] pxl_q;

    logic          ers_en_q;
    logic [AW-1:0] ers_addr_q;
    logic          ers_bank_q;

    logic          clearing;
    logic          running;
    logic          draw_we;
    logic [AW-1:0] a_addr;
    logic [DW-1:0] a_din;
    logic [1:0]    a_we;
    logic [1:0]    b_we;
    logic [DW-1:0] dout [2];
    logic [DW-1:0] disp_dout;

    assign clearing = (state_q == ST_CLEAR);
    assign running  = (state_q == ST_RUN);

    // Drawer writes only opaque pixels; transparent ones leave earlier sprites visible
    assign draw_we  = running && !rst && wr_en && is_opaque(wr_data[3:0]);

    // Screen flip mirrors the visible 256 pixels but keeps the upper half select
    assign scr_addr  = {hdump[8], hdump[7:0] ^ {8{flip}}};
    assign rd_addr_d = scr_addr[AW-1:0];

    // Display bank is always the one the drawer is not using
    assign disp_dout = bank_q ? dout[0] : dout[1];

    assign a_addr = clearing ? clr_cnt_q : wr_addr;
    assign a_din  = clearing ? '0 : wr_data;

    // Per-bank write enables: clear hits both banks, draw and erase hit one each
    always_comb begin
        a_we = 2'b00;
        b_we = 2'b00;
        if (clearing) begin
            a_we = 2'b11;
        end else if (draw_we) begin
            a_we[bank_q] = 1'b1;
        end
        if (ers_en_q) begin
            b_we[ers_bank_q] = 1'b1;
        end
    end

    // Post-reset clear sweep: one address per clk in both banks, then run
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_CLEAR: begin
                    clr_cnt_q <= clr_cnt_q + 1'b1;
                    if (clr_cnt_q == '1) begin
                        state_q <= ST_RUN;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    // Bank swap on the rising edge of hs, sampled at pixel rate, also during clear
    always_ff @(posedge clk) begin
        if (rst) begin
            bank_q <= 1'b0;
            hs_l_q <= 1'b0;
        end else if (pxl_cen) begin
            hs_l_q <= hs;
            if (hs && !hs_l_q) begin
                bank_q <= ~bank_q;
            end
        end
    end

    // Read pipeline (address then data) with the erase of each captured cell one clk later
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_q  <= '0;
            pxl_q      <= '0;
            ers_en_q   <= 1'b0;
            ers_addr_q <= '0;
            ers_bank_q <= 1'b0;
        end else begin
            ers_en_q <= 1'b0;
            if (pxl_cen) begin
                rd_addr_q <= rd_addr_d;
                if (running) begin
                    pxl_q      <= disp_dout;
                    ers_en_q   <= 1'b1;
                    ers_addr_q <= rd_addr_q;
                    ers_bank_q <= ~bank_q;
                end else begin
                    pxl_q <= '0;
                end
            end
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_bank
        jtframe_dual_ram #(
            .DW (DW),
            .AW (AW)
        ) u_ram (
            .clk_i     (clk),
            .a_we_i    (a_we[gi]),
            .a_addr_i  (a_addr),
            .a_din_i   (a_din),
            .b_we_i    (b_we[gi]),
            .b_waddr_i (ers_addr_q),
            .b_din_i   ('0),
            .b_raddr_i (rd_addr_q),
            .b_dout_o  (dout[gi])
        );
    end

    assign busy = busy_q;
    assign pxl  = pxl_q;

endmodule

// File: tb/tb_jtkunio_objbuf.sv
// tb/tb_jtkunio_objbuf.sv - self-checking bench for the object line buffer
module tb_jtkunio_objbuf;

    logic       clk = 1'b0;
    logic       rst;
    logic       pxl_cen;
    logic       hs;
    logic [8:0] hdump;
    logic       flip;
    logic [8:0] wr_addr;
    logic [4:0] wr_data;
    logic       wr_en;
    logic       busy;
    logic [4:0] pxl;

    int checks = 0;
    int errors = 0;

    jtkunio_objbuf u_dut (
        .clk     (clk),
        .rst     (rst),
        .pxl_cen (pxl_cen),
        .hs      (hs),
        .hdump   (hdump),
        .flip    (flip),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_en   (wr_en),
        .busy    (busy),
        .pxl     (pxl)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // Reference model: two line arrays, the bank selector and the pixel pipeline
    logic [4:0] m_mem [0:1][0:511];
    bit         m_bank, m_hsl, m_busy, m_ep, m_ebank;
    int         m_clr, m_addr, m_eaddr;
    logic [4:0] m_pxl;

    function automatic int faddr(input int hd, input bit fl);
        return (hd & 256) | ((hd & 255) ^ (fl ? 255 : 0));
    endfunction

    task automatic model_edge();
        logic [4:0] rd;
        bit         old_ep;
        if (rst) begin
            for (int b = 0; b < 2; b++)
                for (int a = 0; a < 512; a++) m_mem[b][a] = 5'd0;
            m_bank = 0; m_hsl = 0; m_busy = 1; m_clr = 512;
            m_pxl = 5'd0; m_addr = 0; m_ep = 0; m_eaddr = 0; m_ebank = 0;
            return;
        end
        rd = m_mem[!m_bank][m_addr];
        old_ep = m_ep;
        m_ep = 0;
        if (old_ep) m_mem[m_ebank][m_eaddr] = 5'd0;
        if (!m_busy && wr_en && wr_data[3:0] != 4'd0) m_mem[m_bank][int'(wr_addr)] = wr_data;
        if (pxl_cen) begin
            if (!m_busy) begin
                m_pxl = rd; m_ep = 1; m_eaddr = m_addr; m_ebank = !m_bank;
            end
            m_addr = faddr(int'(hdump), flip);
            if (hs && !m_hsl) m_bank = !m_bank;
            m_hsl = hs;
        end
        if (m_busy) begin
            m_clr--;
            if (m_clr == 0) m_busy = 0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic clk_step(input bit cen);
        pxl_cen = cen;
        @(posedge clk);
        model_edge();
        #1;
        check("pxl_model", 32'(pxl), 32'(m_pxl));
        check("busy_model", 32'(busy), 32'(m_busy));
    endtask

    task automatic draw(input int addr, input logic [4:0] data);
        wr_en = 1'b1; wr_addr = 9'(addr); wr_data = data;
        clk_step(1'b0);
        wr_en = 1'b0;
    endtask

    task automatic swap(input bit with_wr, input int addr, input logic [4:0] data);
        hdump = 9'd511;
        hs = 1'b1;
        if (with_wr) begin
            wr_en = 1'b1; wr_addr = 9'(addr); wr_data = data;
        end
        clk_step(1'b1);
        wr_en = 1'b0;
        clk_step(1'b0);
        hs = 1'b0;
        clk_step(1'b1);
        clk_step(1'b0);
    endtask

    logic [4:0] line_out [0:383];

    task automatic show_line();
        for (int h = 0; h <= 384; h++) begin
            hdump = (h == 384) ? 9'd0 : 9'(h);
            clk_step(1'b1);
            if (h > 0) line_out[h-1] = pxl;
            clk_step(1'b0);
        end
        hdump = 9'd511;
    endtask

    function automatic int count_nz();
        int n = 0;
        for (int h = 0; h < 384; h++) if (line_out[h] != 5'd0) n++;
        return n;
    endfunction

    task automatic wait_clear(input string name);
        int n = 0;
        while (busy === 1'b1 && n < 600) begin
            clk_step(1'(n % 2));
            n++;
        end
        check(name, 32'(n), 32'd512);
    endtask

    typedef struct {
        int         waddr;
        logic [4:0] wdata;
        bit         fl;
        int         hd;
        logic [4:0] exp;
    } vec_t;

    vec_t tbl [8];

    initial begin
        tbl[0] = '{20,  5'h13, 1'b0, 20,  5'h13};
        tbl[1] = '{21,  5'h00, 1'b0, 21,  5'h00};
        tbl[2] = '{235, 5'h07, 1'b1, 20,  5'h07};
        tbl[3] = '{300, 5'h1F, 1'b0, 300, 5'h1F};
        tbl[4] = '{479, 5'h11, 1'b1, 288, 5'h11};
        tbl[5] = '{5,   5'h10, 1'b0, 5,   5'h00};
        tbl[6] = '{383, 5'h0C, 1'b0, 383, 5'h0C};
        tbl[7] = '{0,   5'h09, 1'b0, 0,   5'h09};

        rst = 1'b1; pxl_cen = 1'b0; hs = 1'b0; hdump = 9'd511; flip = 1'b0;
        wr_addr = 9'd0; wr_data = 5'd0; wr_en = 1'b0;
        for (int i = 0; i < 3; i++) clk_step(1'b0);
        check("reset_busy", 32'(busy), 32'd1);
        check("reset_pxl", 32'(pxl), 32'd0);
        rst = 1'b0;

        // Clear length, with writes attempted during clear that must be ignored
        wr_en = 1'b1; wr_addr = 9'd20; wr_data = 5'h1F;
        wait_clear("clear_len");
        wr_en = 1'b0;
        for (int i = 512; i < 600; i++) clk_step(1'(i % 2));

        // Both banks read back empty over every address
        show_line(); check("init_bank0_f0", 32'(count_nz()), 32'd0);
        flip = 1'b1; show_line(); check("init_bank0_f1", 32'(count_nz()), 32'd0);
        flip = 1'b0; swap(1'b0, 0, 5'd0);
        show_line(); check("init_bank1_f0", 32'(count_nz()), 32'd0);
        flip = 1'b1; show_line(); check("init_bank1_f1", 32'(count_nz()), 32'd0);
        flip = 1'b0;

        // Table: draw one pixel, swap, show a line, look for it at the expected dump position
        for (int k = 0; k < 8; k++) begin
            flip = tbl[k].fl;
            draw(tbl[k].waddr, tbl[k].wdata);
            swap(1'b0, 0, 5'd0);
            show_line();
            check($sformatf("tbl%0d_pix", k), 32'(line_out[tbl[k].hd]), 32'(tbl[k].exp));
            check($sformatf("tbl%0d_count", k), 32'(count_nz()), (tbl[k].exp != 5'd0) ? 32'd1 : 32'd0);
        end
        flip = 1'b0;

        // Two pixels in one line, transparent neighbour
        draw(20, 5'h13); draw(21, 5'h00);
        swap(1'b0, 0, 5'd0);
        show_line();
        check("pair_20", 32'(line_out[20]), 32'h13);
        check("pair_21", 32'(line_out[21]), 32'h00);

        // Write on the swap clk lands in the bank that is displayed next
        swap(1'b1, 50, 5'h0A);
        show_line();
        check("swapclk_50", 32'(line_out[50]), 32'h0A);
        check("swapclk_count", 32'(count_nz()), 32'd1);

        // Shown line was erased: bring it back without drawing
        swap(1'b0, 0, 5'd0);
        swap(1'b0, 0, 5'd0);
        show_line();
        check("erase_count", 32'(count_nz()), 32'd0);

        // Reset while drawing mid-line
        for (int i = 0; i < 20; i++) draw($urandom_range(0, 383), 5'(16 + $urandom_range(1, 15)));
        wr_en = 1'b1; wr_addr = 9'd77; wr_data = 5'h15;
        rst = 1'b1;
        clk_step(1'b1);
        rst = 1'b0; wr_en = 1'b0;
        check("midrst_busy", 32'(busy), 32'd1);
        wait_clear("midrst_clear_len");
        swap(1'b0, 0, 5'd0);
        show_line(); check("midrst_line_a", 32'(count_nz()), 32'd0);
        swap(1'b0, 0, 5'd0);
        show_line(); check("midrst_line_b", 32'(count_nz()), 32'd0);

        // Randomised traffic checked cycle by cycle against the model
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 59) == 0) hs = ~hs;
            if ($urandom_range(0, 499) == 0) flip = ~flip;
            hdump   = 9'($urandom_range(0, 383));
            wr_en   = 1'($urandom_range(0, 1));
            wr_addr = 9'($urandom_range(0, 511));
            wr_data = 5'($urandom_range(0, 31));
            rst     = (i == 2000);
            clk_step(1'($urandom_range(0, 1)));
        end
        rst = 1'b0; wr_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
